// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the fetch front end. Holds the major
//                opcode constants, the instruction-fetch FSM state encoding,
//                the default reset PC and a small opcode-extraction helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes (instr[31:26]) recognised by the Control stage
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // IF FSM: IDLE = nothing outstanding, REQ = live request,
    // DRAIN = outstanding request whose data will be thrown away
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    function automatic logic [5:0] get_opcode(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small registered FIFO holding fetched {instr, pc} pairs.
//                Head entry is read straight from storage registers, so the
//                output never depends combinationally on the write data.
//                Flush has priority over push and pop. DEPTH must be a power
//                of two (2 or 4 in this design).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Issues one word fetch at a time to
//                instruction memory, buffers returned words with their PC in
//                a small fetch queue and presents the head to decode. Handles
//                redirects (flush + refetch) including requests that are
//                still outstanding when the redirect arrives.
//  Options     : define IF_PERF_CNT_EN to add saturating fetch_cnt/flush_cnt
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int OW = CW + 1;

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] redir_pc_al;
    logic [CW-1:0] fq_count;
    logic        fq_full;
    logic        fq_empty;
    logic [63:0] fq_dout;
    logic        push;
    logic        pop;
    logic [OW-1:0] occ_after;

    assign redir_pc_al = {redirect_pc[31:2], 2'b00};

    assign instr_valid = !fq_empty;
    assign pop         = instr_valid && !stall && !redirect;
    assign push        = (state_q == IF_REQ) && imem_ack && !redirect;

    // Occupancy once this cycle's push and pop are applied; decides whether a
    // back-to-back request can be issued right after an ack
    assign occ_after = {1'b0, fq_count} + OW'(1) - OW'(pop);

    // The request address is held in its own register so it stays put while
    // a redirect retargets fetch_pc during DRAIN
    assign imem_req  = (state_q != IF_IDLE);
    assign imem_addr = req_addr_q;

    assign instr    = fq_dout[63:32];
    assign instr_pc = fq_dout[31:0];
    assign opcode   = get_opcode(instr);

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_i  ({imem_rdata, fetch_pc_q}),
        .data_o  (fq_dout),
        .full_o  (fq_full),
        .empty_o (fq_empty),
        .count_o (fq_count)
    );

    // FSM state, fetch PC and latched request address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state, fetch PC advance and redirect handling
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            IF_IDLE: begin
                if (redirect) begin
                    // Queue is flushed this cycle, so a slot is guaranteed
                    fetch_pc_d = redir_pc_al;
                    req_addr_d = redir_pc_al;
                    state_d    = IF_REQ;
                end else if (!fq_full) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = IF_REQ;
                end
            end
            IF_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_d = redir_pc_al;
                        state_d    = IF_IDLE;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (occ_after < OW'(FQ_DEPTH)) begin
                            req_addr_d = fetch_pc_q + 32'd4;
                            state_d    = IF_REQ;
                        end else begin
                            state_d = IF_IDLE;
                        end
                    end
                end else if (redirect) begin
                    fetch_pc_d = redir_pc_al;
                    state_d    = IF_DRAIN;
                end
            end
            IF_DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc_al;
                end
                if (imem_ack) begin
                    state_d = IF_IDLE;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counts of instructions handed to decode and of redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire
